// File: rtl/farm_vehicle_sensor_pkg.sv
// Shared definitions for the farm-road vehicle sensor: FSM state encoding,
// the farm_light level that means GREEN, and default parameter values.
package farm_vehicle_sensor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAITING = 2'd1,
        SERVING = 2'd2,
        FAULT   = 2'd3
    } state_t;

    // farm_light is 0 only while the farm road is GREEN
    localparam logic GREEN_LEVEL = 1'b0;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 4;
    localparam int DEF_STUCK_CYCLES    = 64;

endpackage

// File: rtl/farm_vehicle_sensor_if.sv
// Detector inputs, controller feedback and queue status of the farm-road
// vehicle sensor. The master side drives the detectors and farm_light;
// the slave side (the sensor) reports queue status.
interface farm_vehicle_sensor_if #(
    parameter int CNT_W = 4
);
    logic             loop_raw;
    logic             exit_raw;
    logic             farm_light;
    logic             car_present;
    logic [CNT_W-1:0] queue_count;
    logic             overflow;
    logic             sensor_fault;

    modport master (
        output loop_raw, exit_raw, farm_light,
        input  car_present, queue_count, overflow, sensor_fault
    );

    modport slave (
        input  loop_raw, exit_raw, farm_light,
        output car_present, queue_count, overflow, sensor_fault
    );
endinterface

// File: rtl/farm_vehicle_sensor_debounce.sv
// Conditions one raw detector: two-flop synchronizer, debounce counter that
// flips the stable level after DEBOUNCE_CYCLES consecutive disagreeing edges,
// and a one-cycle pulse in the cycle after the stable level rises.
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam logic [3:0] LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       sync_p0;
    logic       sync_p1;
    logic [3:0] cnt;

    // Bring the asynchronous detector into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive disagreements; flip the level on the last one and
    // flag a rising flip so the event is visible in the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'd0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_p1 != level) begin
                if (cnt == LAST) begin
                    level <= sync_p1;
                    rise  <= sync_p1;
                    cnt   <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end else begin
                cnt <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/farm_vehicle_sensor.sv
// Farm-road vehicle detection front end: debounces arrival/exit detectors,
// tracks the number of queued farm cars and drives car_present for the
// light controller, with a sticky fail-safe recall when the loop sticks.
module farm_vehicle_sensor
    import farm_vehicle_sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
    input logic            clk,
    input logic            reset,
    farm_vehicle_sensor_if.slave bus
);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;
    localparam int               STUCK_W   = $clog2(STUCK_CYCLES + 1);
    localparam logic [STUCK_W-1:0] STUCK_LAST = STUCK_W'(STUCK_CYCLES - 1);

    logic loop_level, loop_rise;
    logic exit_level, exit_rise;
    logic green, arrival, departure;
    logic stuck_hit, ovf_set;

    logic [STUCK_W-1:0] stuck_cnt;
    logic [CNT_W-1:0]   count_q, count_next;
    state_t             state_q, state_next;
    logic               car_q, ovf_q, fault_q;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_loop (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.loop_raw),
        .level (loop_level),
        .rise  (loop_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.exit_raw),
        .level (exit_level),
        .rise  (exit_rise)
    );

    assign green     = (bus.farm_light == GREEN_LEVEL);
    assign arrival   = loop_rise;
    // An exit seen while the farm road is red is not a real departure
    assign departure = exit_rise & exit_level & green;
    assign stuck_hit = loop_level & green & (stuck_cnt == STUCK_LAST);

    // Count edges of continuous loop occupancy during green
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stuck_cnt <= '0;
        end else if (loop_level && green) begin
            if (stuck_cnt != STUCK_LAST) begin
                stuck_cnt <= stuck_cnt + STUCK_W'(1);
            end
        end else begin
            stuck_cnt <= '0;
        end
    end

    // Queue update: simultaneous arrival and departure cancel out
    always_comb begin
        count_next = count_q;
        ovf_set    = 1'b0;
        unique case ({arrival, departure})
            2'b10: begin
                if (count_q == COUNT_MAX) ovf_set = 1'b1;
                else                      count_next = count_q + CNT_W'(1);
            end
            2'b01: begin
                if (count_q != '0) count_next = count_q - CNT_W'(1);
            end
            default: count_next = count_q;
        endcase
    end

    // Next-state selection; a stuck loop overrides everything
    always_comb begin
        state_next = state_q;
        if (stuck_hit) begin
            state_next = FAULT;
        end else begin
            unique case (state_q)
                IDLE:    if (count_next != '0) state_next = WAITING;
                WAITING: if (count_next == '0) state_next = IDLE;
                         else if (green)       state_next = SERVING;
                SERVING: if (count_next == '0) state_next = IDLE;
                         else if (!green)      state_next = WAITING;
                FAULT:   state_next = FAULT;
                default: state_next = IDLE;
            endcase
        end
    end

    // State, queue count and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            car_q   <= 1'b0;
            ovf_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_next;
            count_q <= count_next;
            car_q   <= (state_next != IDLE);
            ovf_q   <= ovf_q | ovf_set;
            fault_q <= fault_q | stuck_hit;
        end
    end

    assign bus.car_present  = car_q;
    assign bus.queue_count  = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.sensor_fault = fault_q;

endmodule

// File: tb/tb_farm_vehicle_sensor.sv
// Scoreboard bench for farm_vehicle_sensor: directed stimulus pushes the
// expected status snapshot {fault, overflow, car_present, queue_count} for
// every output change; a monitor pops and compares on each observed change.
module tb_farm_vehicle_sensor;
    import farm_vehicle_sensor_pkg::*;

    localparam int CNT_W = 4;
    localparam int SW    = CNT_W + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] prev_snap = '0;

    farm_vehicle_sensor_if #(.CNT_W(CNT_W)) bus ();

    farm_vehicle_sensor #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (CNT_W),
        .STUCK_CYCLES   (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] mk(input bit f, input bit o, input bit c, input int n);
        return {f, o, c, CNT_W'(n)};
    endfunction

    function automatic logic [SW-1:0] snap();
        return {bus.sensor_fault, bus.overflow, bus.car_present, bus.queue_count};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold detectors high for 8 cycles then low for 8 cycles
    task automatic pulse(input bit lp, input bit ex);
        bus.loop_raw = lp;
        bus.exit_raw = ex;
        step(8);
        bus.loop_raw = 1'b0;
        bus.exit_raw = 1'b0;
        step(8);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, int'(bus.queue_count), 0);
        check({tag, "_car"}, int'(bus.car_present), 0);
        check({tag, "_ovf"}, int'(bus.overflow), 0);
        check({tag, "_fault"}, int'(bus.sensor_fault), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.loop_raw = 1'b0;
        bus.exit_raw = 1'b0;
        step(2);
        check_zero("reset");
        reset = 1'b0;
        step(2);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Monitor: every change of the status outputs must match the next expectation
    always @(negedge clk) begin
        logic [SW-1:0] cur;
        logic [SW-1:0] e;
        if (reset) begin
            prev_snap = '0;
        end else begin
            cur = snap();
            if (cur != prev_snap) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change actual=%b expected=no change", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        bad++;
                        $display("FAIL status actual=f%0b o%0b c%0b n%0d expected=f%0b o%0b c%0b n%0d",
                                 cur[SW-1], cur[SW-2], cur[SW-3], cur[CNT_W-1:0],
                                 e[SW-1], e[SW-2], e[SW-3], e[CNT_W-1:0]);
                    end
                end
                prev_snap = cur;
            end
        end
    end

    initial begin
        bus.loop_raw   = 1'b0;
        bus.exit_raw   = 1'b0;
        bus.farm_light = 1'b1;
        step(1);
        do_reset();
        check("reset_state", int'(dut.state_q), int'(IDLE));

        // Short glitch is filtered
        bus.loop_raw = 1'b1;
        step(3);
        bus.loop_raw = 1'b0;
        step(10);
        check("glitch_count", int'(bus.queue_count), 0);
        check("glitch_car", int'(bus.car_present), 0);

        // Clean arrival: visible on the 7th edge
        exp_q.push_back(mk(0, 0, 1, 1));
        bus.loop_raw = 1'b1;
        step(6);
        check("lat_edge6_count", int'(bus.queue_count), 0);
        step(1);
        check("lat_edge7_count", int'(bus.queue_count), 1);
        check("lat_edge7_car", int'(bus.car_present), 1);
        check("state_waiting", int'(dut.state_q), int'(WAITING));
        step(3);
        bus.loop_raw = 1'b0;
        step(8);

        // Two more arrivals, exit during red ignored, then three departures
        exp_q.push_back(mk(0, 0, 1, 2));
        pulse(1, 0);
        exp_q.push_back(mk(0, 0, 1, 3));
        pulse(1, 0);
        pulse(0, 1);
        check("red_exit_count", int'(bus.queue_count), 3);
        bus.farm_light = 1'b0;
        step(2);
        check("state_serving", int'(dut.state_q), int'(SERVING));
        exp_q.push_back(mk(0, 0, 1, 2));
        pulse(0, 1);
        exp_q.push_back(mk(0, 0, 1, 1));
        pulse(0, 1);
        exp_q.push_back(mk(0, 0, 0, 0));
        pulse(0, 1);
        check("state_idle", int'(dut.state_q), int'(IDLE));
        drain("departures");

        // Simultaneous arrival and departure at count 2
        bus.farm_light = 1'b1;
        exp_q.push_back(mk(0, 0, 1, 1));
        pulse(1, 0);
        exp_q.push_back(mk(0, 0, 1, 2));
        pulse(1, 0);
        bus.farm_light = 1'b0;
        step(2);
        pulse(1, 1);
        check("simul_count", int'(bus.queue_count), 2);
        exp_q.push_back(mk(0, 0, 1, 1));
        pulse(0, 1);
        exp_q.push_back(mk(0, 0, 0, 0));
        pulse(0, 1);

        // Saturation and overflow
        bus.farm_light = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            exp_q.push_back(mk(0, 0, 1, i));
            pulse(1, 0);
        end
        exp_q.push_back(mk(0, 1, 1, 15));
        pulse(1, 0);
        check("sat_count", int'(bus.queue_count), 15);
        check("sat_ovf", int'(bus.overflow), 1);
        drain("saturate");

        // Stuck loop during green declares a fault
        do_reset();
        bus.farm_light = 1'b0;
        exp_q.push_back(mk(0, 0, 1, 1));
        exp_q.push_back(mk(1, 0, 1, 1));
        bus.loop_raw = 1'b1;
        step(80);
        bus.loop_raw = 1'b0;
        step(10);
        check("fault_flag", int'(bus.sensor_fault), 1);
        check("fault_car", int'(bus.car_present), 1);
        check("fault_state", int'(dut.state_q), int'(FAULT));
        exp_q.push_back(mk(1, 0, 1, 0));
        pulse(0, 1);
        check("fault_recall_car", int'(bus.car_present), 1);
        drain("fault");

        // Reset mid-debounce with a populated queue
        do_reset();
        bus.farm_light = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(mk(0, 0, 1, i));
            pulse(1, 0);
        end
        drain("prefill");
        check("prefill_count", int'(bus.queue_count), 5);
        bus.loop_raw = 1'b1;
        step(3);
        #1;
        reset = 1'b1;
        bus.loop_raw = 1'b0;
        #1;
        check_zero("async");
        step(2);
        reset = 1'b0;
        step(3);
        exp_q.push_back(mk(0, 0, 1, 1));
        pulse(1, 0);
        check("post_reset_count", int'(bus.queue_count), 1);
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/farm_vehicle_sensor.md
Name: farm_vehicle_sensor

Overview:
Vehicle-detection front end that generates the car_present input consumed by the farm/highway light controller. It closes the loop on that controller's farm_light output. It conditions the raw inductive-loop (arrival) and stop-line (exit) detector signals and keeps a count of cars queued on the farm road. It asserts car_present while any car is waiting, and adds a fail-safe recall if the loop sensor sticks.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clock edges a synchronized detector must disagree with its stable level before that level flips (range 1..15)
CNT_W, 4, queue counter width; queue saturates at 2^CNT_W-1
STUCK_CYCLES, 64, consecutive green cycles with the loop continuously occupied that declare a sensor fault

Ports:
clk  input  1  single system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
loop_raw  input  1  raw arrival loop detector, asynchronous, noisy
exit_raw  input  1  raw stop-line exit detector, asynchronous, noisy
farm_light  input  1  controller farm light: 0 = GREEN, 1 = TRAN_RED/RED (also 1 under emergency)
car_present  output  1  registered; 1 = at least one farm car waiting, or fault recall
queue_count  output  CNT_W  registered number of queued farm cars
overflow  output  1  sticky; arrival seen while queue_count at maximum
sensor_fault  output  1  sticky; loop stuck occupied during green

Behaviour:
- Reset (async, any time, including mid-debounce): all synchronizers, debounce counters and stable levels are 0; queue_count=0; car_present=0; overflow=0; sensor_fault=0; FSM=IDLE. Flags clear only on reset.
- Synchronizer: two flops per raw input.
- Debounce, per detector: the counter increments on each edge where the sync output differs from the stable level, and clears on agreement. On the DEBOUNCE_CYCLES-th consecutive mismatch edge, the stable level flips and the counter clears. Glitches shorter than DEBOUNCE_CYCLES edges are ignored.
- Events: arrival = rising edge of the stable loop level. Departure = rising edge of the stable exit level AND farm_light==0. An exit rising edge during red is discarded.
- Counter update, on the edge after the event cycle:
  - arrival only: +1; at max it holds and overflow is set.
  - departure only: -1; at 0 it holds with no flag (underflow ignored).
  - arrival and departure together: unchanged, even at max or 0.
- Latency: a clean loop_raw rise reaches car_present on the (DEBOUNCE_CYCLES+3)-th edge after it is first sampled (7 edges at default).
- FSM states:
  - IDLE: count==0. Arrival -> WAITING.
  - WAITING: count>0 and farm_light==1. farm_light==0 -> SERVING. Net count reaching 0 -> IDLE.
  - SERVING: count>0 and farm_light==0. count reaching 0 -> IDLE. farm_light==1 -> WAITING.
  - FAULT: entered from any state when the stable loop level stays 1 for STUCK_CYCLES consecutive edges with farm_light==0. The stuck counter clears whenever the loop level is 0 or farm_light is 1. Exit only via reset.
- car_present is registered and equals 1 when the next state is WAITING, SERVING or FAULT, and 0 in IDLE.
- In FAULT, queue_count keeps tracking events but car_present is forced to 1 (fail-safe recall).
- Emergency forces farm_light to 1, so departures are blocked during emergency; this is intended.

Decomposition:
- Shared package: FSM state encodings (IDLE, WAITING, SERVING, FAULT), GREEN_LEVEL=0 for farm_light, default parameter constants.
- One sub-module, sensor_debounce (2-flop synchronizer + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice, once for loop and once for exit.

Test Plan:
- Reset then a clean loop_raw pulse held 10 cycles, farm_light=1 -> queue_count=1 and car_present=1 on edge 7; FSM WAITING.
- loop_raw glitch of 3 cycles (DEBOUNCE_CYCLES=4) -> no arrival; queue_count stays 0 and car_present stays 0.
- 3 arrivals, then farm_light=0 and 3 exit pulses -> count goes 3,2,1,0; car_present drops with the last departure; FSM IDLE. An exit pulse given while farm_light=1 leaves the count unchanged.
- Arrival and departure pulses landing on the same cycle with count=2 -> count stays 2. 16 arrivals from 0 with CNT_W=4 -> count saturates at 15 and overflow=1.
- loop_raw held 1 with farm_light=0 for 70 cycles -> sensor_fault=1 and car_present=1; both persist after loop_raw=0 until reset.
- Reset asserted mid-debounce with count=5 -> all outputs 0 immediately (async); the first new arrival after release gives count=1.
